// File: rtl/round_sequencer_if.sv
// Signal bundle between the round sequencer and the pinball screen blocks:
// frame/key/collision inputs plus the phase, score and indication outputs.
interface round_sequencer_if;
    logic       startOfFrame;
    logic       key5IsPressed;
    logic       collisionSmileyBorderBottom;
    logic       collisionSmileyObstacleGood;
    logic       collisionSmileyObstacleBad;
    logic       pause;
    logic       reset_level;
    logic       reset_level_pulse;
    logic [3:0] life;
    logic [3:0] score;
    logic [3:0] level;
    logic       game_over;
    logic       game_won;
    logic [2:0] state;

    modport slave (
        input  startOfFrame, key5IsPressed,
        input  collisionSmileyBorderBottom, collisionSmileyObstacleGood, collisionSmileyObstacleBad,
        output pause, reset_level, reset_level_pulse,
        output life, score, level, game_over, game_won, state
    );

    modport master (
        output startOfFrame, key5IsPressed,
        output collisionSmileyBorderBottom, collisionSmileyObstacleGood, collisionSmileyObstacleBad,
        input  pause, reset_level, reset_level_pulse,
        input  life, score, level, game_over, game_won, state
    );
endinterface

// File: rtl/round_sequencer.sv
// Frame-synchronous game-round controller: sequences serve/play/pause/loss/level
// phases and folds per-pixel collision strobes into one update per frame.
module round_sequencer #(
    parameter int unsigned INIT_LIFE       = 3,
    parameter int unsigned SCORE_PER_LEVEL = 9,
    parameter int unsigned MAX_LEVEL       = 4,
    parameter int unsigned SERVE_FRAMES    = 60,
    parameter int unsigned LOST_FRAMES     = 90
) (
    input  logic               clk,
    input  logic               resetN,
    round_sequencer_if.slave   bus
);

    localparam int unsigned TMAX = (SERVE_FRAMES > LOST_FRAMES) ? SERVE_FRAMES : LOST_FRAMES;
    localparam int unsigned TW   = $clog2(TMAX + 1);

    localparam logic [3:0]    INIT_LIFE_C = 4'(INIT_LIFE);
    localparam logic [3:0]    SPL_C       = 4'(SCORE_PER_LEVEL);
    localparam logic [3:0]    MAX_LEVEL_C = 4'(MAX_LEVEL);
    localparam logic [TW-1:0] SERVE_T     = TW'(SERVE_FRAMES);
    localparam logic [TW-1:0] LOST_T      = TW'(LOST_FRAMES);
    localparam logic [TW-1:0] T_ONE       = TW'(1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SERVE     = 3'd1,
        ST_PLAY      = 3'd2,
        ST_PAUSED    = 3'd3,
        ST_BALL_LOST = 3'd4,
        ST_LEVEL_UP  = 3'd5,
        ST_LOST_GAME = 3'd6,
        ST_WON_GAME  = 3'd7
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    life_q, life_d;
    logic [3:0]    score_q, score_d;
    logic [3:0]    level_q, level_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          key_q, press_q;
    logic          lat_bot_q, lat_bad_q, lat_good_q;
    logic          entry_q;
    logic          pause_q, reset_level_q, pulse_q, game_over_q, game_won_q;

    logic          ev_bot_s, ev_bad_s, ev_good_s, ev_any_s;
    logic [3:0]    life_dec_s;

    function automatic logic pause_of(input state_t s);
        case (s)
            ST_PLAY: pause_of = 1'b0;
            default: pause_of = 1'b1;
        endcase
    endfunction

    function automatic logic reset_level_of(input state_t s);
        case (s)
            ST_IDLE, ST_SERVE, ST_LOST_GAME, ST_WON_GAME: reset_level_of = 1'b1;
            default:                                      reset_level_of = 1'b0;
        endcase
    endfunction

    // Frame evaluation: latched events plus any strobe landing on the frame-start cycle.
    always_comb begin
        ev_bot_s   = bus.startOfFrame & (lat_bot_q  | bus.collisionSmileyBorderBottom);
        ev_bad_s   = bus.startOfFrame & (lat_bad_q  | bus.collisionSmileyObstacleBad);
        ev_good_s  = bus.startOfFrame & (lat_good_q | bus.collisionSmileyObstacleGood);
        ev_any_s   = ev_bot_s | ev_bad_s | ev_good_s;
        life_dec_s = (life_q == 4'd0) ? 4'd0 : (life_q - 4'd1);
    end

    // Next-state and counter update logic.
    always_comb begin
        state_d = state_q;
        life_d  = life_q;
        score_d = score_q;
        level_d = level_q;
        timer_d = timer_q;
        case (state_q)
            ST_IDLE: begin
                if (press_q) begin
                    state_d = ST_SERVE;
                    timer_d = SERVE_T;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SERVE: begin
                if (bus.startOfFrame) begin
                    if (timer_q <= T_ONE) begin
                        state_d = ST_PLAY;
                    end else begin
                        timer_d = timer_q - T_ONE;
                    end
                end else begin
                    timer_d = timer_q;
                end
            end
            ST_PLAY: begin
                // A frame event takes precedence over a coincident key press.
                if (ev_any_s) begin
                    if (ev_bot_s) begin
                        life_d  = life_dec_s;
                        state_d = ST_BALL_LOST;
                        timer_d = LOST_T;
                    end else if (ev_bad_s) begin
                        life_d = life_dec_s;
                        if (life_dec_s == 4'd0) begin
                            state_d = ST_BALL_LOST;
                            timer_d = LOST_T;
                        end else begin
                            state_d = ST_PLAY;
                        end
                    end else begin
                        score_d = score_q + 4'd1;
                        if ((score_q + 4'd1) == SPL_C) begin
                            state_d = ST_LEVEL_UP;
                        end else begin
                            state_d = ST_PLAY;
                        end
                    end
                end else if (press_q) begin
                    state_d = ST_PAUSED;
                end else begin
                    state_d = ST_PLAY;
                end
            end
            ST_PAUSED: begin
                if (press_q) begin
                    state_d = ST_PLAY;
                end else begin
                    state_d = ST_PAUSED;
                end
            end
            ST_BALL_LOST: begin
                if (bus.startOfFrame) begin
                    if (timer_q > T_ONE) begin
                        timer_d = timer_q - T_ONE;
                    end else if (life_q == 4'd0) begin
                        state_d = ST_LOST_GAME;
                    end else begin
                        state_d = ST_SERVE;
                        timer_d = SERVE_T;
                    end
                end else begin
                    timer_d = timer_q;
                end
            end
            ST_LEVEL_UP: begin
                score_d = 4'd0;
                if (level_q == MAX_LEVEL_C) begin
                    state_d = ST_WON_GAME;
                end else begin
                    level_d = level_q + 4'd1;
                    state_d = ST_SERVE;
                    timer_d = SERVE_T;
                end
            end
            ST_LOST_GAME, ST_WON_GAME: begin
                if (press_q) begin
                    state_d = ST_IDLE;
                    life_d  = INIT_LIFE_C;
                    score_d = 4'd0;
                    level_d = 4'd1;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counters, key edge detector, event latches and registered outputs.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q       <= ST_IDLE;
            life_q        <= INIT_LIFE_C;
            score_q       <= 4'd0;
            level_q       <= 4'd1;
            timer_q       <= '0;
            // Previous key level resets as "held" so a key held through reset is not a press.
            key_q         <= 1'b1;
            press_q       <= 1'b0;
            lat_bot_q     <= 1'b0;
            lat_bad_q     <= 1'b0;
            lat_good_q    <= 1'b0;
            entry_q       <= 1'b0;
            pause_q       <= 1'b1;
            reset_level_q <= 1'b1;
            pulse_q       <= 1'b0;
            game_over_q   <= 1'b0;
            game_won_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            life_q        <= life_d;
            score_q       <= score_d;
            level_q       <= level_d;
            timer_q       <= timer_d;
            key_q         <= bus.key5IsPressed;
            press_q       <= bus.key5IsPressed & ~key_q;
            if (bus.startOfFrame) begin
                lat_bot_q  <= 1'b0;
                lat_bad_q  <= 1'b0;
                lat_good_q <= 1'b0;
            end else begin
                lat_bot_q  <= lat_bot_q  | bus.collisionSmileyBorderBottom;
                lat_bad_q  <= lat_bad_q  | bus.collisionSmileyObstacleBad;
                lat_good_q <= lat_good_q | bus.collisionSmileyObstacleGood;
            end
            entry_q       <= (state_d == ST_SERVE) && (state_q != ST_SERVE);
            pulse_q       <= entry_q;
            pause_q       <= pause_of(state_q);
            reset_level_q <= reset_level_of(state_q);
            game_over_q   <= (state_q == ST_LOST_GAME);
            game_won_q    <= (state_q == ST_WON_GAME);
        end
    end

    assign bus.pause             = pause_q;
    assign bus.reset_level       = reset_level_q;
    assign bus.reset_level_pulse = pulse_q;
    assign bus.life              = life_q;
    assign bus.score             = score_q;
    assign bus.level             = level_q;
    assign bus.game_over         = game_over_q;
    assign bus.game_won          = game_won_q;
    assign bus.state             = state_q;

endmodule

// File: tb/tb_round_sequencer.sv
// Directed bench for round_sequencer: expected state/life/score/level snapshots are
// queued as stimulus is applied and popped for comparison once the DUT has updated.
module tb_round_sequencer;

    logic clk = 1'b0;
    logic resetN;
    int   checks   = 0;
    int   failures = 0;

    typedef struct {
        string      tag;
        logic [2:0] st;
        logic [3:0] life;
        logic [3:0] score;
        logic [3:0] level;
    } exp_t;

    exp_t sb_q[$];

    round_sequencer_if bus ();

    round_sequencer dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sof();
        bus.startOfFrame = 1'b1;
        tick(1);
        bus.startOfFrame = 1'b0;
    endtask

    task automatic sofs(input int n);
        repeat (n) begin
            tick(2);
            sof();
        end
    endtask

    task automatic press();
        bus.key5IsPressed = 1'b1;
        tick(1);
        bus.key5IsPressed = 1'b0;
        tick(1);
    endtask

    task automatic strobes(input logic bot, input logic bad, input logic good, input int n);
        bus.collisionSmileyBorderBottom = bot;
        bus.collisionSmileyObstacleBad  = bad;
        bus.collisionSmileyObstacleGood = good;
        tick(n);
        bus.collisionSmileyBorderBottom = 1'b0;
        bus.collisionSmileyObstacleBad  = 1'b0;
        bus.collisionSmileyObstacleGood = 1'b0;
        tick(1);
        sof();
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [2:0] st, input logic [3:0] life,
                        input logic [3:0] score, input logic [3:0] level);
        exp_t e;
        e.tag = tag; e.st = st; e.life = life; e.score = score; e.level = level;
        sb_q.push_back(e);
    endtask

    task automatic pop_cmp();
        exp_t e;
        checks++;
        assert (sb_q.size() != 0) else begin
            failures++;
            $error("FAIL sb_empty observed=%0d expected=1", sb_q.size());
        end
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk({e.tag, "_state"}, {1'b0, bus.state}, {1'b0, e.st});
            chk({e.tag, "_life"},  bus.life,  e.life);
            chk({e.tag, "_score"}, bus.score, e.score);
            chk({e.tag, "_level"}, bus.level, e.level);
        end
    endtask

    initial begin
        resetN                          = 1'b0;
        bus.startOfFrame                = 1'b0;
        bus.key5IsPressed               = 1'b1;
        bus.collisionSmileyBorderBottom = 1'b0;
        bus.collisionSmileyObstacleGood = 1'b0;
        bus.collisionSmileyObstacleBad  = 1'b0;
        tick(3);

        // 1: key held through reset is not a press; a clean press serves
        chk("rst_pause", {3'd0, bus.pause}, 4'd1);
        chk("rst_reset_level", {3'd0, bus.reset_level}, 4'd1);
        resetN = 1'b1;
        tick(5);
        push("t1_held", 3'd0, 4'd3, 4'd0, 4'd1);
        pop_cmp();
        bus.key5IsPressed = 1'b0;
        tick(2);
        press();
        push("t1_serve", 3'd1, 4'd3, 4'd0, 4'd1);
        pop_cmp();
        tick(1);
        chk("t1_pulse_hi", {3'd0, bus.reset_level_pulse}, 4'd1);
        tick(1);
        chk("t1_pulse_lo", {3'd0, bus.reset_level_pulse}, 4'd0);
        sofs(59);
        push("t1_serve59", 3'd1, 4'd3, 4'd0, 4'd1);
        pop_cmp();
        sofs(1);
        push("t1_play", 3'd2, 4'd3, 4'd0, 4'd1);
        pop_cmp();
        tick(1);
        chk("t1_pause_lo", {3'd0, bus.pause}, 4'd0);
        chk("t1_reset_level_lo", {3'd0, bus.reset_level}, 4'd0);

        // 2: 40 good strobes per frame score once per frame; ninth frame levels up
        for (int k = 1; k <= 8; k++) begin
            strobes(1'b0, 1'b0, 1'b1, 40);
            push("t2_score", 3'd2, 4'd3, 4'(k), 4'd1);
            pop_cmp();
        end
        strobes(1'b0, 1'b0, 1'b1, 40);
        push("t2_lvlup", 3'd5, 4'd3, 4'd9, 4'd1);
        pop_cmp();
        tick(1);
        push("t2_serve", 3'd1, 4'd3, 4'd0, 4'd2);
        pop_cmp();
        tick(1);
        chk("t2_pulse", {3'd0, bus.reset_level_pulse}, 4'd1);

        // 3: bottom+bad+good in one frame: bottom wins, single life lost
        sofs(60);
        strobes(1'b0, 1'b0, 1'b1, 1);
        strobes(1'b0, 1'b0, 1'b1, 1);
        push("t3_pre", 3'd2, 4'd3, 4'd2, 4'd2);
        pop_cmp();
        strobes(1'b1, 1'b1, 1'b1, 3);
        push("t3_lost", 3'd4, 4'd2, 4'd2, 4'd2);
        pop_cmp();
        sofs(89);
        push("t3_lost89", 3'd4, 4'd2, 4'd2, 4'd2);
        pop_cmp();
        sofs(1);
        push("t3_serve", 3'd1, 4'd2, 4'd2, 4'd2);
        pop_cmp();

        // 4: bad hits drain the last life, then the game is lost
        sofs(60);
        strobes(1'b0, 1'b1, 1'b0, 1);
        push("t4_bad1", 3'd2, 4'd1, 4'd2, 4'd2);
        pop_cmp();
        strobes(1'b0, 1'b1, 1'b0, 1);
        push("t4_bad0", 3'd4, 4'd0, 4'd2, 4'd2);
        pop_cmp();
        sofs(90);
        push("t4_lost_game", 3'd6, 4'd0, 4'd2, 4'd2);
        pop_cmp();
        tick(1);
        chk("t4_game_over", {3'd0, bus.game_over}, 4'd1);
        press();
        push("t4_idle", 3'd0, 4'd3, 4'd0, 4'd1);
        pop_cmp();

        // 5: pause freezes scoring; resume scores on the next frame
        press();
        sofs(60);
        press();
        push("t5_paused", 3'd3, 4'd3, 4'd0, 4'd1);
        pop_cmp();
        tick(1);
        chk("t5_pause_hi", {3'd0, bus.pause}, 4'd1);
        repeat (5) strobes(1'b0, 1'b0, 1'b1, 2);
        push("t5_frozen", 3'd3, 4'd3, 4'd0, 4'd1);
        pop_cmp();
        press();
        push("t5_resume", 3'd2, 4'd3, 4'd0, 4'd1);
        pop_cmp();
        strobes(1'b0, 1'b0, 1'b1, 1);
        push("t5_score", 3'd2, 4'd3, 4'd1, 4'd1);
        pop_cmp();

        // 6: climb to the last level and win, then reset mid-state
        repeat (8) strobes(1'b0, 1'b0, 1'b1, 1);
        tick(1);
        push("t6_lvl2", 3'd1, 4'd3, 4'd0, 4'd2);
        pop_cmp();
        sofs(60);
        repeat (9) strobes(1'b0, 1'b0, 1'b1, 1);
        tick(1);
        push("t6_lvl3", 3'd1, 4'd3, 4'd0, 4'd3);
        pop_cmp();
        sofs(60);
        repeat (9) strobes(1'b0, 1'b0, 1'b1, 1);
        tick(1);
        push("t6_lvl4", 3'd1, 4'd3, 4'd0, 4'd4);
        pop_cmp();
        sofs(60);
        repeat (8) strobes(1'b0, 1'b0, 1'b1, 1);
        push("t6_pre", 3'd2, 4'd3, 4'd8, 4'd4);
        pop_cmp();
        strobes(1'b0, 1'b0, 1'b1, 1);
        push("t6_lvlup", 3'd5, 4'd3, 4'd9, 4'd4);
        pop_cmp();
        tick(1);
        push("t6_won", 3'd7, 4'd3, 4'd0, 4'd4);
        pop_cmp();
        tick(1);
        chk("t6_game_won", {3'd0, bus.game_won}, 4'd1);
        chk("t6_game_over", {3'd0, bus.game_over}, 4'd0);
        #3;
        resetN = 1'b0;
        #1;
        push("t6_reset", 3'd0, 4'd3, 4'd0, 4'd1);
        pop_cmp();
        chk("t6_rst_pause", {3'd0, bus.pause}, 4'd1);
        chk("t6_rst_reset_level", {3'd0, bus.reset_level}, 4'd1);
        chk("t6_rst_pulse", {3'd0, bus.reset_level_pulse}, 4'd0);
        chk("t6_rst_game_won", {3'd0, bus.game_won}, 4'd0);
        chk("t6_rst_game_over", {3'd0, bus.game_over}, 4'd0);
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
